// File: rtl/vga_framebuffer_sink.sv
// Pixel-plot sink: writes a 160x120x3 frame memory and scans it out as 640x480@60 VGA.
// Optional DOUBLE_BUFFER_EN: two banks, swapped at the vsync line after a completed frame.
module vga_framebuffer_sink #(
    parameter int unsigned XRES         = 160,
    parameter int unsigned YRES         = 120,
    parameter int unsigned SCALE_LOG2   = 2,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 752,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 492
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] color,
    input  logic       plotPixel,
    output logic       frame_done,
    output logic       oob_err,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int unsigned MEM_DEPTH = XRES * YRES;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(XRES << SCALE_LOG2);
    localparam logic [9:0] V_VIS    = 10'(YRES << SCALE_LOG2);
    localparam logic [9:0] HS_START = 10'(H_SYNC_START);
    localparam logic [9:0] HS_END   = 10'(H_SYNC_END);
    localparam logic [9:0] VS_START = 10'(V_SYNC_START);
    localparam logic [9:0] VS_END   = 10'(V_SYNC_END);

`ifdef DOUBLE_BUFFER_EN
    localparam int unsigned BANKS = 2;
`else
    localparam int unsigned BANKS = 1;
`endif
    localparam int unsigned IDX_W = $clog2(BANKS * MEM_DEPTH);

    logic              pix_en;
    logic [9:0]        h;
    logic [9:0]        v;
    logic              in_range;
    logic              wr_en;
    logic              last_px;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              vis;
    logic              hs_raw;
    logic              vs_raw;
    logic [2:0]        rd_data;
    logic [2:0]        mem [BANKS*MEM_DEPTH];

    always_comb begin
        in_range = (32'(x) < XRES) && (32'(y) < YRES);
        wr_en    = plotPixel && in_range;
        last_px  = (32'(x) == XRES - 1) && (32'(y) == YRES - 1);
        wr_addr  = ADDR_W'(y) * ADDR_W'(XRES) + ADDR_W'(x);
        rd_addr  = ADDR_W'(v >> SCALE_LOG2) * ADDR_W'(XRES) + ADDR_W'(h >> SCALE_LOG2);
        vis      = (h < H_VIS) && (v < V_VIS);
        hs_raw   = !((h >= HS_START) && (h < HS_END));
        vs_raw   = !((v >= VS_START) && (v < VS_END));
    end

`ifdef DOUBLE_BUFFER_EN
    logic wr_bank;
    logic pending;
    logic swap_now;

    // Swap on the tick that moves the scan onto the first vsync line.
    always_comb begin
        swap_now = pix_en && (h == H_LAST) && (v == VS_START - 10'd1) && pending;
        wr_idx   = IDX_W'(wr_addr) + (wr_bank ? IDX_W'(MEM_DEPTH) : '0);
        rd_idx   = IDX_W'(rd_addr) + (wr_bank ? '0 : IDX_W'(MEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_bank <= 1'b0;
            pending <= 1'b0;
        end else if (swap_now) begin
            wr_bank <= !wr_bank;
            pending <= frame_done;
        end else if (frame_done) begin
            pending <= 1'b1;
        end
    end
`else
    always_comb begin
        wr_idx = wr_addr;
        rd_idx = rd_addr;
    end
`endif

    // Frame memory is never cleared; read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem[wr_idx] <= color;
        end
        if (pix_en && vis) begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            frame_done <= wr_en && last_px;
            if (plotPixel && !in_range) begin
                oob_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_en      <= 1'b0;
            h           <= '0;
            v           <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            pix_en <= !pix_en;
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
                // Timing registered alongside the memory read so both land on the same tick.
                vga_hs      <= hs_raw;
                vga_vs      <= vs_raw;
                vga_blank_n <= vis;
            end
        end
    end

    always_comb begin
        vga_r = (vga_blank_n && rd_data[2]) ? 8'hFF : 8'h00;
        vga_g = (vga_blank_n && rd_data[1]) ? 8'hFF : 8'h00;
        vga_b = (vga_blank_n && rd_data[0]) ? 8'hFF : 8'h00;
    end

endmodule
